// File: rtl/regfile_pkg.sv
// Shared types and constants for the scoreboarded register file.
package regfile_pkg;

   // Clear sequencer states.
   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } clr_state_t;

   // Address of the hardwired-zero register.
   localparam int unsigned REG_ZERO = 0;

endpackage : regfile_pkg

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks the index from 1 to NREG-1, one register per cycle.
//   clk, reset : clock and synchronous active-high reset
//   clear_req  : start a sweep (sampled only while idle)
//   busy       : registered, high while sweeping
//   clr_en     : zero the entry at clr_idx on this edge
//   clr_idx    : entry being cleared
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int unsigned NREG = 32,
   parameter int unsigned AW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear_req,
   output logic          busy,
   output logic          clr_en,
   output logic [AW-1:0] clr_idx
);

   clr_state_t    state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          busy_q, busy_d;

   // State, index and busy registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state logic; register 0 needs no clearing so the sweep starts at 1.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      busy_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (clear_req) begin
               state_d = SWEEP;
               idx_d   = AW'(1);
            end
         end
         SWEEP: begin
            idx_d = idx_q + AW'(1);
            if (idx_q == AW'(NREG - 1)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == SWEEP);
   end

   assign busy    = busy_q;
   assign clr_en  = busy_q;
   assign clr_idx = idx_q;

endmodule : regfile_clear_seq

// File: rtl/regfile_sb.sv
// Register file with pending scoreboard and sequenced clear.
//   clk, reset            : clock and synchronous active-high reset
//   rs1/rs2_addr          : read addresses
//   rs1/rs2_data          : combinational read data (optionally bypassed)
//   rs1/rs2_pending       : addressed register awaits a write
//   rd_addr/wr_en/wr_data : synchronous write port
//   issue_en/issue_addr   : mark a destination register pending
//   clear_req             : start a clear sweep
//   busy                  : clear sweep in progress
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NREG   = 32,
   parameter int unsigned BYPASS = 1,
   localparam int unsigned AW    = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            rs1_pending,
   output logic            rs2_pending,
   input  logic [AW-1:0]   rd_addr,
   input  logic            wr_en,
   input  logic [XLEN-1:0] wr_data,
   input  logic            issue_en,
   input  logic [AW-1:0]   issue_addr,
   input  logic            clear_req,
   output logic            busy
);

   logic [XLEN-1:0] mem_q [NREG];
   logic [NREG-1:0] pend_q;
   logic            busy_int;
   logic            clr_en;
   logic [AW-1:0]   clr_idx;
   logic            wr_ok;
   logic            iss_ok;
   logic            byp1;
   logic            byp2;

   regfile_clear_seq #(
      .NREG (NREG),
      .AW   (AW)
   ) u_clear_seq (
      .clk       (clk),
      .reset     (reset),
      .clear_req (clear_req & ~busy_int),
      .busy      (busy_int),
      .clr_en    (clr_en),
      .clr_idx   (clr_idx)
   );

   // Writes and issues are dropped while sweeping or when aimed at register 0.
   assign wr_ok  = wr_en    & ~busy_int & (rd_addr    != AW'(REG_ZERO));
   assign iss_ok = issue_en & ~busy_int & (issue_addr != AW'(REG_ZERO));

   // Storage and scoreboard; issue is applied after write so a new producer wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            mem_q[i] <= '0;
         end
         pend_q <= '0;
      end else if (clr_en) begin
         mem_q[clr_idx]  <= '0;
         pend_q[clr_idx] <= 1'b0;
      end else begin
         if (wr_ok) begin
            mem_q[rd_addr]  <= wr_data;
            pend_q[rd_addr] <= 1'b0;
         end
         if (iss_ok) begin
            pend_q[issue_addr] <= 1'b1;
         end
      end
   end

   // Forward only writes that will actually land this cycle.
   assign byp1 = (BYPASS != 0) && wr_ok && (rd_addr == rs1_addr);
   assign byp2 = (BYPASS != 0) && wr_ok && (rd_addr == rs2_addr);

   assign rs1_data    = byp1 ? wr_data : mem_q[rs1_addr];
   assign rs2_data    = byp2 ? wr_data : mem_q[rs2_addr];
   assign rs1_pending = pend_q[rs1_addr] & ~byp1;
   assign rs2_pending = pend_q[rs2_addr] & ~byp2;
   assign busy        = busy_int;

endmodule : regfile_sb
